// File: rtl/processor_n_bits_v2.sv
// Multicycle bus processor with N-bit datapath: eight registers, A/G accumulator
// pair, one shared bus, eight opcodes including a zero-flag conditional move.
module processor_n_bits_v2 #(
  parameter int N  = 9,
  parameter int IW = 9
) (
  input  logic         clock,
  input  logic         Reset,
  input  logic         Run,
  input  logic [N-1:0] DataIn,
  output logic [N-1:0] Bus_Wires,
  output logic         Done,
  output logic         Zero
);

  localparam logic [1:0] T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_MVNZ = 3'b111;

  logic [1:0]          state, next_state;
  logic [IW-1:0]       ir;
  logic [7:0][N-1:0]   r;
  logic [N-1:0]        a, g, alu;

  logic [2:0] opc, rx, ry;
  logic       sel_din, sel_g, ir_in, a_in, g_in;
  logic [7:0] sel_r, r_in;

  assign opc = ir[8:6];
  assign rx  = ir[5:3];
  assign ry  = ir[2:0];

  always_comb begin
    next_state = state;
    sel_din    = 1'b0;
    sel_g      = 1'b0;
    sel_r      = '0;
    r_in       = '0;
    ir_in      = 1'b0;
    a_in       = 1'b0;
    g_in       = 1'b0;
    Done       = 1'b0;
    case (state)
      T0: if (Run) begin
        ir_in      = 1'b1;
        next_state = T1;
      end
      T1: begin
        case (opc)
          OP_MV: begin
            sel_r[ry] = 1'b1;
            r_in[rx]  = 1'b1;
            Done      = 1'b1;
            next_state = T0;
          end
          OP_MVNZ: begin
            sel_r[ry] = 1'b1;
            r_in[rx]  = ~Zero;
            Done      = 1'b1;
            next_state = T0;
          end
          OP_MVI: begin
            sel_din  = 1'b1;
            r_in[rx] = 1'b1;
            Done     = 1'b1;
            next_state = T0;
          end
          default: begin
            sel_r[rx]  = 1'b1;
            a_in       = 1'b1;
            next_state = T2;
          end
        endcase
      end
      T2: begin
        sel_r[ry]  = 1'b1;
        g_in       = 1'b1;
        next_state = T3;
      end
      default: begin
        sel_g      = 1'b1;
        r_in[rx]   = 1'b1;
        Done       = 1'b1;
        next_state = T0;
      end
    endcase
  end

  // Single-source bus; idle cycles drive zero rather than DataIn.
  always_comb begin
    Bus_Wires = '0;
    if (sel_din)    Bus_Wires = DataIn;
    else if (sel_g) Bus_Wires = g;
    else
      for (int i = 0; i < 8; i++)
        if (sel_r[i]) Bus_Wires = r[i];
  end

  always_comb begin
    case (opc)
      OP_ADD:  alu = a + Bus_Wires;
      OP_SUB:  alu = a - Bus_Wires;
      OP_AND:  alu = a & Bus_Wires;
      OP_OR:   alu = a | Bus_Wires;
      OP_XOR:  alu = a ^ Bus_Wires;
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state <= T0;
      ir    <= '0;
      r     <= '0;
      a     <= '0;
      g     <= '0;
      Zero  <= 1'b1;
    end else begin
      state <= next_state;
      if (ir_in) ir <= DataIn[IW-1:0];
      for (int i = 0; i < 8; i++)
        if (r_in[i]) r[i] <= Bus_Wires;
      if (a_in) a <= Bus_Wires;
      if (g_in) begin
        g    <= alu;
        Zero <= (alu == '0);
      end
    end
  end

endmodule
